// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: blank pattern, hex font, FSM states.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}, indexed by hex nibble.
    localparam logic [6:0] FONT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic {BLANK, SHOW} state_t;

endpackage

// File: rtl/seg_hex_font.sv
// Combinational hex nibble to active-low 7-segment glyph lookup.
module seg_hex_font
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = FONT[nibble];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with frame-aligned double buffering and per-slot dead time.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS      = 6,
    parameter int SEL_W       = 3,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  load,
    output logic [SEL_W-1:0]      sel,
    output logic [7:0]            seg,
    output logic                  frame_tick
);

    localparam int               CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_V   = CNT_W'(DEAD_CYC);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [SEL_W-1:0]    idx, idx_nxt;
    state_t              state, state_nxt;
    logic [4*DIGITS-1:0] pend_din, act_din, act_din_nxt;
    logic [DIGITS-1:0]   pend_dp, act_dp, act_dp_nxt;
    logic                dirty;
    logic                slot_end, frame_end, swap;
    logic [3:0]          nib;
    logic                dp_bit, blank_hit;
    logic [6:0]          glyph;
    logic [7:0]          seg_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= '0;
            state <= BLANK;
        end else begin
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            state <= state_nxt;
        end
    end

    always_comb begin
        slot_end  = (cnt == CNT_LAST);
        frame_end = slot_end && (idx == IDX_LAST);
        cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
        idx_nxt   = idx;
        if (slot_end)
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;

        state_nxt = state;
        case (state)
            BLANK:   if (cnt_nxt >= DEAD_V) state_nxt = SHOW;
            SHOW:    if (slot_end && DEAD_CYC != 0) state_nxt = BLANK;
            default: state_nxt = BLANK;
        endcase
    end

    // Outputs are registered from the post-edge view (next index, next active buffer)
    // so sel/seg/frame_tick all change on the slot's opening edge.
    always_comb begin
        swap        = frame_end && dirty;
        act_din_nxt = swap ? pend_din : act_din;
        act_dp_nxt  = swap ? pend_dp  : act_dp;
    end

`ifdef SEG_LZB_EN
    logic [DIGITS-1:0] blank_map, blank_nxt;

    function automatic logic [DIGITS-1:0] lzb_map(input logic [4*DIGITS-1:0] d,
                                                  input logic [DIGITS-1:0]   m);
        logic [DIGITS-1:0] map;
        logic              lead;
        int unsigned       i;
        map  = '0;
        lead = 1'b1;
        for (int unsigned k = 0; k < DIGITS - 1; k++) begin
            i = DIGITS - 1 - k;
            if (lead && d[4*i +: 4] == 4'h0 && !m[i])
                map[i] = 1'b1;
            else
                lead = 1'b0;
        end
        return map;
    endfunction

    always_comb begin
        blank_nxt = swap ? lzb_map(pend_din, pend_dp) : blank_map;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blank_map <= '0;
        else
            blank_map <= blank_nxt;
    end
`endif

    always_comb begin
        nib       = '0;
        dp_bit    = 1'b0;
        blank_hit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_nxt == SEL_W'(i)) begin
                nib    = act_din_nxt[4*i +: 4];
                dp_bit = act_dp_nxt[i];
`ifdef SEG_LZB_EN
                blank_hit = blank_nxt[i];
`endif
            end
        end
    end

    seg_hex_font u_font (
        .nibble (nib),
        .glyph  (glyph)
    );

    always_comb begin
        seg_nxt = {~dp_bit, glyph};
        if (state_nxt == BLANK || blank_hit)
            seg_nxt = SEG_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_din   <= '0;
            pend_dp    <= '0;
            dirty      <= 1'b0;
            act_din    <= '0;
            act_dp     <= '0;
            sel        <= '1;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            act_din <= act_din_nxt;
            act_dp  <= act_dp_nxt;
            // A load on the swap edge re-arms dirty for the following frame.
            if (load) begin
                pend_din <= din;
                pend_dp  <= dp_mask;
                dirty    <= 1'b1;
            end else if (swap) begin
                dirty <= 1'b0;
            end
            sel        <= idx_nxt;
            seg        <= seg_nxt;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=6, REFRESH_DIV=8, DEAD_CYC=2.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] din = '0;
    logic [5:0]  dp_mask = '0;
    logic        load = 1'b0;
    logic [2:0]  sel;
    logic [7:0]  seg;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [6:0] font [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg_scan_driver #(
        .DIGITS      (6),
        .SEL_W       (3),
        .REFRESH_DIV (8),
        .DEAD_CYC    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .dp_mask    (dp_mask),
        .load       (load),
        .sel        (sel),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_tick();
        int guard;
        guard = 0;
        while (frame_tick !== 1'b1 && guard < 200) begin
            step();
            guard++;
        end
        check_eq("tick_seen", {31'd0, frame_tick}, 32'd1);
        check_eq("tick_latency", cyc, 48);
    endtask

    // Checks one whole frame starting on its frame_tick cycle; optionally pulses load at cycle load_at.
    task automatic scan_frame(input logic [23:0] d, input logic [5:0] m, input int load_at,
                              input logic [23:0] ld_d, input logic [5:0] ld_m);
        logic [5:0] bl;
        logic [7:0] e;
        logic [3:0] n;
        int         dg, s;
        bl = '0;
`ifdef SEG_LZB_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int k = 5; k >= 1; k--) begin
                if (lead && d[4*k +: 4] == 4'h0 && !m[k]) bl[k] = 1'b1;
                else lead = 1'b0;
            end
        end
`endif
        for (int c = 0; c < 48; c++) begin
            dg = c / 8;
            s  = c % 8;
            n  = d[4*dg +: 4];
            if (s < 2 || bl[dg]) e = 8'hFF;
            else                 e = {~m[dg], font[n]};
            check_eq("sel", {29'd0, sel}, dg);
            check_eq("seg", {24'd0, seg}, {24'd0, e});
            check_eq("tick", {31'd0, frame_tick}, (c == 0) ? 32'd1 : 32'd0);
            if (c == load_at) begin
                load = 1'b1; din = ld_d; dp_mask = ld_m;
                step();
                load = 1'b0;
            end else begin
                step();
            end
        end
    endtask

    initial begin
        #12;
        check_eq("rst_sel", {29'd0, sel}, 32'd7);
        check_eq("rst_seg", {24'd0, seg}, 32'hFF);
        check_eq("rst_tick", {31'd0, frame_tick}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;

        repeat (20) step();
        check_eq("pre_sel", {29'd0, sel}, 32'd2);
        check_eq("pre_seg", {24'd0, seg}, 32'hC0);
        load = 1'b1; din = 24'h123456; dp_mask = 6'b000100;
        step();
        load = 1'b0;
        repeat (9) step();
        check_eq("mid_sel", {29'd0, sel}, 32'd3);
        check_eq("mid_seg", {24'd0, seg}, 32'hC0);
        wait_tick();

        scan_frame(24'h123456, 6'b000100, 47, 24'hABCDEF, 6'b000000);
        scan_frame(24'h123456, 6'b000100, -1, 24'h0, 6'b0);
        scan_frame(24'hABCDEF, 6'b000000, 0, 24'h000050, 6'b001000);
        scan_frame(24'h000050, 6'b001000, 5, 24'h000050, 6'b000000);
        scan_frame(24'h000050, 6'b000000, -1, 24'h0, 6'b0);

        load = 1'b1; din = 24'h888888; dp_mask = 6'b111111;
        step();
        load = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_sel", {29'd0, sel}, 32'd7);
        check_eq("mid_rst_seg", {24'd0, seg}, 32'hFF);
        check_eq("mid_rst_tick", {31'd0, frame_tick}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        repeat (20) step();
        check_eq("post_rst_sel", {29'd0, sel}, 32'd2);
        check_eq("post_rst_seg", {24'd0, seg}, 32'hC0);
        wait_tick();
        check_eq("post_rst_blank", {24'd0, seg}, 32'hFF);
        repeat (10) step();
        check_eq("discard_sel", {29'd0, sel}, 32'd1);
        check_eq("discard_seg", {24'd0, seg}, 32'hC0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed 7-segment scan driver: successor of the fixed six-digit BCD display driver. Takes a packed vector of DIGITS hex nibbles plus a per-digit decimal-point mask, double-buffers it so updates only land on frame boundaries, and scans the digits through a binary select bus to an external decoder. Each slot opens with a dead-time blank to suppress ghosting. Sits between the counter/clock datapath and the board's segment and select pins.

## Interface
- DIGITS, 6: number of digits scanned, 2..(2^SEL_W − 1).
- SEL_W, 3: select bus width; all-ones code is reserved as "no digit".
- REFRESH_DIV, 50000: clocks per digit slot (1 ms at 50 MHz); ≥ 2.
- DEAD_CYC, 500: blank clocks at the start of each slot; 0 ≤ DEAD_CYC < REFRESH_DIV.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- din  in  4*DIGITS  hex nibbles; digit i = din[4i+3:4i], digit 0 least significant.
- dp_mask  in  DIGITS  1 = light decimal point of digit i.
- load  in  1  single-cycle strobe: capture din/dp_mask into pending buffer.
- sel  out  SEL_W  binary digit index to external 3-8 decoder.
- seg  out  8  active-low {dp,g,f,e,d,c,b,a}.
- frame_tick  out  1  one-cycle pulse when digit 0's slot begins.

## Operation
- Reset values: sel = all-ones, seg = 8'hFF, frame_tick = 0, pending and active buffers = 0, dp masks = 0, digit index = 0, slot counter = 0, state = BLANK.
- Slot counter 0..REFRESH_DIV−1, width $clog2(REFRESH_DIV); wraps to 0 and advances digit index (DIGITS−1 wraps to 0).
- FSM per slot: BLANK while counter < DEAD_CYC (seg = 8'hFF, sel = current index); SHOW otherwise (seg = decoded glyph). DEAD_CYC = 0: BLANK never entered after reset's first cycle.
- Buffering: load captures din and dp_mask into pending and sets a dirty flag. At the start of digit 0's slot, if dirty, active ← pending and dirty clears. Display reads only active.
- Simultaneous load and frame boundary in the same cycle: active takes the old pending; new capture sets dirty and applies next frame.
- Font: hex 0–F, active-low g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- dp bit = ~active_dp[index] in SHOW, 1 in BLANK.

## Timing
- sel and seg are registered; both change on the clock edge that starts the slot; seg goes 8'hFF on that same edge.
- frame_tick asserted for exactly the first cycle of digit 0's slot (the cycle sel changes to 0).
- Frame period = DIGITS × REFRESH_DIV clocks; first frame_tick occurs REFRESH_DIV × DIGITS clocks after reset release (digit 0 is shown directly after reset without a tick).
- load to visible glyph: ≤ one frame + DEAD_CYC + 1 clocks.
- Reset mid-slot: all outputs return to reset values asynchronously; pending load discarded.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking. From the most significant digit down, a digit with nibble 0 and dp_mask 0 shows seg = 8'hFF in SHOW until the first non-zero or dp-marked digit; digit 0 is never blanked. Blank map computed from active at buffer swap.
- Not defined: every digit is always decoded; no blank map logic.

## Structure
- Package seg_pkg: SEG_OFF = 8'hFF, 16-entry font constant array, FSM state enum {BLANK, SHOW}.
- Sub-module seg_hex_font: combinational nibble → 7-bit active-low glyph; everything else stays in seg_scan_driver.

## Test plan
- Reset: assert rst mid-slot → sel = 3'b111, seg = 8'hFF, frame_tick = 0 the same cycle.
- DIGITS=6, REFRESH_DIV=8, DEAD_CYC=2, load din=24'h123456, dp_mask=6'b000100 → next frame digit 2 shows seg = 8'h19 (dp lit on "4"), sel cycles 0..5, each slot starts with 2 cycles of 8'hFF.
- Load in mid-frame → displayed value unchanged until the frame_tick, then new value; frame_tick period exactly 48 clocks.
- Load on the frame_tick cycle → new data appears one frame later.
- Hex glyphs: din=24'hABCDEF → seg low 7 bits 0001000, 0000011, 1000110, 0100001, 0000110, 0001110 (A…F).
- SEG_LZB_EN: din=24'h000050 → digits 5..2 blank (8'hFF), digit 1 = 5, digit 0 = 0; with dp_mask=6'b001000 digit 3 shows "0." and only digits 5..4 blank.
